// File: rtl/mem_refill_arbiter_if.sv
// Bus bundle between the I/D refill requesters, the refill arbiter and the
// external 32-bit memory port.
// slave  : the arbiter's view (takes requests, drives the memory port).
// master : the environment's view (requesters and memory).
interface mem_refill_arbiter_if #(
    parameter int BURST_LEN = 4
);
    localparam int LINE_W = BURST_LEN * 32;

    // Instruction-side refill
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic [LINE_W-1:0] i_rdata;
    logic              i_done;

    // Data-side refill / write-back
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_gnt;
    logic [LINE_W-1:0] d_rdata;
    logic              d_done;

    // External memory port
    logic              mem_ena;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    // Status
    logic              err;
    logic              busy;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_ready, mem_rdata,
        output i_gnt, i_rdata, i_done,
        output d_gnt, d_rdata, d_done,
        output mem_ena, mem_we, mem_addr, mem_wdata,
        output err, busy
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_ready, mem_rdata,
        input  i_gnt, i_rdata, i_done,
        input  d_gnt, d_rdata, d_done,
        input  mem_ena, mem_we, mem_addr, mem_wdata,
        input  err, busy
    );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Refill arbiter: shares one 32-bit memory port between the I-side line
// refill path and the D-side refill/write-back path. Round-robin on ties,
// one BURST_LEN-word line transfer per grant.
// Optional build macro REFILL_ARB_TIMEOUT_EN adds a per-beat wait limit of
// TIMEOUT cycles; an expired beat ends the burst with done and err together.
module mem_refill_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int LINE_W    = BURST_LEN * 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst,   // asynchronous, active-low
    mem_refill_arbiter_if.slave bus
);

    localparam int CW  = $clog2(BURST_LEN);
    localparam int OFF = CW + 2;
    localparam logic [31:0]   LINE_MASK = ~((32'd1 << OFF) - 32'd1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [31:0]       base_q, base_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LINE_W-1:0] i_line_q, i_line_d;
    logic [LINE_W-1:0] d_line_q, d_line_d;
    logic              pick_d;
    logic [CW+4:0]     bit_sel;
    logic              busy_w;
    logic              in_burst;

`ifdef REFILL_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] wait_q, wait_d;
    logic          tmo_q, tmo_d;
`endif

    // Bit offset of the current beat's word inside a line
    assign bit_sel  = {cnt_q, 5'd0};
    assign busy_w   = (state_q != IDLE);
    assign in_burst = (state_q == BURST);

    // Next-state, arbitration and line datapath
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        base_d       = base_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        i_line_d     = i_line_q;
        d_line_d     = d_line_q;
        pick_d       = OWN_I;
`ifdef REFILL_ARB_TIMEOUT_EN
        wait_d       = wait_q;
        tmo_d        = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // Tie goes to whoever did not own the port last time
                    if (bus.i_req && bus.d_req) begin
                        pick_d = ~last_owner_q;
                    end else begin
                        pick_d = bus.d_req ? OWN_D : OWN_I;
                    end
                    owner_d = pick_d;
                    state_d = GRANT;
                    if (pick_d == OWN_D) begin
                        base_d  = bus.d_addr & LINE_MASK;
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                        // A write-back leaves the previous read line visible
                        if (!bus.d_we) begin
                            d_line_d = '0;
                        end
                    end else begin
                        base_d   = bus.i_addr & LINE_MASK;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        i_line_d = '0;
                    end
                end
            end
            GRANT: begin
                cnt_d   = '0;
                state_d = BURST;
`ifdef REFILL_ARB_TIMEOUT_EN
                wait_d  = '0;
                tmo_d   = 1'b0;
`endif
            end
            BURST: begin
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            d_line_d[bit_sel +: 32] = bus.mem_rdata;
                        end else begin
                            i_line_d[bit_sel +: 32] = bus.mem_rdata;
                        end
                    end
                    // Counter parks on the last beat instead of wrapping
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef REFILL_ARB_TIMEOUT_EN
                    wait_d = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
`endif
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            base_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            i_line_q     <= '0;
            d_line_q     <= '0;
`ifdef REFILL_ARB_TIMEOUT_EN
            wait_q       <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            base_q       <= base_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            i_line_q     <= i_line_d;
            d_line_q     <= d_line_d;
`ifdef REFILL_ARB_TIMEOUT_EN
            wait_q       <= wait_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign bus.busy      = busy_w;
    assign bus.i_gnt     = busy_w && (owner_q == OWN_I);
    assign bus.d_gnt     = busy_w && (owner_q == OWN_D);
    assign bus.i_done    = (state_q == DONE) && (owner_q == OWN_I);
    assign bus.d_done    = (state_q == DONE) && (owner_q == OWN_D);
    assign bus.i_rdata   = i_line_q;
    assign bus.d_rdata   = d_line_q;
    assign bus.mem_ena   = in_burst;
    assign bus.mem_we    = in_burst && we_q;
    assign bus.mem_addr  = in_burst ? (base_q | {{(30-CW){1'b0}}, cnt_q, 2'b00}) : 32'd0;
    assign bus.mem_wdata = in_burst ? wdata_q[bit_sel +: 32] : 32'd0;

`ifdef REFILL_ARB_TIMEOUT_EN
    assign bus.err = (state_q == DONE) && tmo_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
